// File: rtl/spi_command_frontend_pkg.sv
// ============================================================================
// Module   : beagleg (package)
// Purpose  : Shared command codes, record geometry and error bit indices for
//            the SPI command frontend.
// Revision : 1.0  initial multi-channel release
// ============================================================================
`default_nettype none

package beagleg;

    localparam int MOTION_SEGMENT_BITS = 64;

    localparam logic [7:0] CMD_STATUS     = 8'h01;
    localparam logic [7:0] CMD_WRITE_FIFO = 8'h02;
    localparam logic [7:0] CMD_FLUSH_FIFO = 8'h03;

    localparam int ERR_UNKNOWN_CMD = 0;
    localparam int ERR_BAD_CHANNEL = 1;
    localparam int ERR_OVERFLOW    = 2;
    localparam int ERR_TRUNCATED   = 3;

    function automatic logic [15:0] channel_onehot(input logic [3:0] ch);
        return 16'(1) << ch;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_command_frontend_record_assembler.sv
// ============================================================================
// Module   : record_assembler
// Purpose  : Byte counter plus MSB-first staging shift register that flags
//            the byte completing a record.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module record_assembler #(
    parameter int RECORD_BYTES = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      byte_strobe,
    input  logic [7:0]                data_byte,
    output logic [RECORD_BYTES*8-1:0] record,
    output logic                      record_done,
    output logic                      pending
);

    localparam int c_cnt_w = (RECORD_BYTES > 1) ? $clog2(RECORD_BYTES) : 1;
    localparam int c_rec_w = RECORD_BYTES * 8;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(RECORD_BYTES - 1);

    logic [c_cnt_w-1:0] r_count;
    logic [c_rec_w-1:0] r_staging;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_staging <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (byte_strobe) begin
            // Earlier bytes drift upward, so byte 0 ends in the top lane.
            r_staging <= c_rec_w'({r_staging, data_byte});
            r_count   <= (r_count == c_last) ? '0 : r_count + 1'b1;
        end
    end

    assign record      = r_staging;
    assign record_done = byte_strobe && !clear && (r_count == c_last);
    assign pending     = (r_count != '0);

endmodule

`default_nettype wire

// File: rtl/spi_command_frontend.sv
// ============================================================================
// Module   : spi_command_frontend
// Purpose  : Decodes SPI host commands, commits whole records to one of
//            several channel FIFOs and reports free slots / sticky errors.
// Revision : 1.0  initial multi-channel release
// ============================================================================
`default_nettype none

module spi_command_frontend
    import beagleg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int RECORD_BYTES = MOTION_SEGMENT_BITS / 8,
    parameter int SLOT_WIDTH   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             spi_cs,
    input  logic                             word_ready,
    input  logic [7:0]                       rx_byte,
    output logic [7:0]                       tx_byte,
    input  logic [NUM_CHANNELS*SLOT_WIDTH-1:0] free_slots,
    output logic [NUM_CHANNELS-1:0]          fifo_write_en,
    output logic [RECORD_BYTES*8-1:0]        fifo_record,
    output logic [NUM_CHANNELS-1:0]          fifo_flush,
    output logic [3:0]                       error_flags
);

    if (MOTION_SEGMENT_BITS % 8 != 0) begin : g_segment_bits_check
        $error("MOTION_SEGMENT_BITS must be a multiple of 8");
    end

    localparam int c_ch_w  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int c_idx_w = $clog2(NUM_CHANNELS + 2);
    localparam logic [c_idx_w-1:0] c_err_idx = c_idx_w'(NUM_CHANNELS);
    localparam logic [7:0] c_num_ch_byte = 8'(NUM_CHANNELS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_RECEIVE = 3'd2,
        S_STATUS  = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

    state_t                  r_state;
    logic                    r_flush_mode;
    logic [c_ch_w-1:0]       r_channel;
    logic [c_idx_w-1:0]      r_status_idx;
    logic [NUM_CHANNELS-1:0] r_write_en;
    logic [NUM_CHANNELS-1:0] r_flush;
    logic [3:0]              r_err;

    logic                    w_rx_strobe;
    logic                    w_asm_strobe;
    logic                    w_asm_clear;
    logic                    w_asm_done;
    logic                    w_asm_pending;
    logic                    w_is_cmd;
    logic                    w_bad_channel;
    logic [SLOT_WIDTH-1:0]   w_sel_slots;
    logic [SLOT_WIDTH-1:0]   w_min_slots;
    logic [SLOT_WIDTH-1:0]   w_status_slots;
    logic [3:0]              w_err_set;
    logic                    w_err_clear;

    assign w_rx_strobe   = word_ready && !spi_cs;
    assign w_asm_strobe  = w_rx_strobe && (r_state == S_RECEIVE);
    assign w_asm_clear   = spi_cs || (r_state != S_RECEIVE);
    assign w_is_cmd      = (rx_byte == CMD_STATUS) || (rx_byte == CMD_WRITE_FIFO) ||
                           (rx_byte == CMD_FLUSH_FIFO);
    assign w_bad_channel = (rx_byte >= c_num_ch_byte);

    record_assembler #(
        .RECORD_BYTES (RECORD_BYTES)
    ) u_record_assembler (
        .clk         (clk),
        .rst         (rst),
        .clear       (w_asm_clear),
        .byte_strobe (w_asm_strobe),
        .data_byte   (rx_byte),
        .record      (fifo_record),
        .record_done (w_asm_done),
        .pending     (w_asm_pending)
    );

    always_comb begin
        w_sel_slots    = '0;
        w_status_slots = '0;
        w_min_slots    = '1;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (c_ch_w'(k) == r_channel)
                w_sel_slots = free_slots[k*SLOT_WIDTH +: SLOT_WIDTH];
            if (c_idx_w'(k) == r_status_idx)
                w_status_slots = free_slots[k*SLOT_WIDTH +: SLOT_WIDTH];
            if (free_slots[k*SLOT_WIDTH +: SLOT_WIDTH] < w_min_slots)
                w_min_slots = free_slots[k*SLOT_WIDTH +: SLOT_WIDTH];
        end
    end

    always_comb begin
        w_err_set                  = '0;
        w_err_set[ERR_UNKNOWN_CMD] = w_rx_strobe && (r_state == S_IDLE) && !w_is_cmd;
        w_err_set[ERR_BAD_CHANNEL] = w_rx_strobe && (r_state == S_SELECT) && w_bad_channel;
        w_err_set[ERR_OVERFLOW]    = w_asm_done && (w_sel_slots == '0);
        w_err_set[ERR_TRUNCATED]   = spi_cs && (r_state == S_RECEIVE) && w_asm_pending;
        w_err_clear = w_rx_strobe && (r_state == S_STATUS) && (r_status_idx == c_err_idx);
    end

    always_comb begin
        tx_byte = 8'h00;
        case (r_state)
            S_IDLE: tx_byte = 8'(w_min_slots);
            S_STATUS: begin
                if (r_status_idx < c_err_idx)
                    tx_byte = 8'(w_status_slots);
                else if (r_status_idx == c_err_idx)
                    tx_byte = {4'b0000, r_err};
            end
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_flush_mode <= 1'b0;
            r_channel    <= '0;
            r_status_idx <= '0;
            r_write_en   <= '0;
            r_flush      <= '0;
            r_err        <= '0;
        end else begin
            r_write_en <= '0;
            r_flush    <= '0;
            // Set wins over a simultaneous status-read clear.
            r_err      <= (w_err_clear ? 4'b0000 : r_err) | w_err_set;

            if (w_asm_done && (w_sel_slots != '0))
                r_write_en <= NUM_CHANNELS'(channel_onehot(4'(r_channel)));

            if (spi_cs) begin
                r_state      <= S_IDLE;
                r_status_idx <= '0;
            end else if (word_ready) begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_byte == CMD_STATUS) begin
                            r_state <= S_STATUS;
                        end else if (rx_byte == CMD_WRITE_FIFO) begin
                            r_state      <= S_SELECT;
                            r_flush_mode <= 1'b0;
                        end else if (rx_byte == CMD_FLUSH_FIFO) begin
                            r_state      <= S_SELECT;
                            r_flush_mode <= 1'b1;
                        end else begin
                            r_state <= S_DISCARD;
                        end
                    end
                    S_SELECT: begin
                        if (w_bad_channel) begin
                            r_state <= S_DISCARD;
                        end else if (r_flush_mode) begin
                            r_flush <= NUM_CHANNELS'(channel_onehot(4'(rx_byte[c_ch_w-1:0])));
                            r_state <= S_DISCARD;
                        end else begin
                            r_channel <= rx_byte[c_ch_w-1:0];
                            r_state   <= S_RECEIVE;
                        end
                    end
                    S_STATUS: begin
                        if (r_status_idx <= c_err_idx)
                            r_status_idx <= r_status_idx + 1'b1;
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign fifo_write_en = r_write_en;
    assign fifo_flush    = r_flush;
    assign error_flags   = r_err;

endmodule

`default_nettype wire

// File: doc/spi_command_frontend.md
Name: spi_command_frontend

Overview:
- Multi-channel successor of the single-FIFO SPI command decoder.
- Sits between spi_secondary (byte stream) and NumChannels motion-segment FIFOs.
- Decodes host commands, assembles whole motion-segment records before committing them to the selected channel FIFO, and reports per-channel free slots and sticky error flags back over SPI.

Parameters:
- NumChannels, 4, number of motion-segment FIFOs served (1..16).
- RecordBytes, beagleg::MotionSegmentBits/8, bytes per record; MotionSegmentBits must be a multiple of 8 (elaboration-time assertion).
- SlotWidth, 8, width of each per-channel free-slot count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- spi_cs  in  1  chip select, active low.
- word_ready  in  1  one-cycle strobe: rx_byte is valid.
- rx_byte  in  8  byte received from host.
- tx_byte  out  8  byte to shift out on the next SPI transfer.
- free_slots  in  NumChannels*SlotWidth  free records per channel; channel k occupies [k*SlotWidth +: SlotWidth].
- fifo_write_en  out  NumChannels  one-hot, one-cycle record-write pulse.
- fifo_record  out  RecordBytes*8  assembled record, shared by all channels.
- fifo_flush  out  NumChannels  one-hot, one-cycle flush pulse.
- error_flags  out  4  sticky errors (also visible over SPI).

Behaviour:
- Reset: state IDLE; byte counter, channel register, status index, staging register, fifo_write_en, fifo_flush and error_flags are all 0.
- States:
  - IDLE
  - SELECT (channel byte pending; mode is write or flush)
  - RECEIVE (record bytes)
  - STATUS
  - DISCARD
- spi_cs high forces state IDLE on the next clock edge.
  - Clears the byte counter and status index.
  - If it interrupts RECEIVE with a nonzero byte counter, error bit3 (truncated) is set and the partial record is dropped.
  - Takes priority over a simultaneous word_ready; that byte is ignored.
- IDLE, on word_ready with spi_cs low:
  - beagleg::CMD_STATUS goes to STATUS.
  - CMD_WRITE_FIFO goes to SELECT(write).
  - CMD_FLUSH_FIFO goes to SELECT(flush).
  - Any other byte goes to DISCARD and sets error bit0 (unknown command).
- SELECT: the byte is a channel index.
  - Index >= NumChannels: go to DISCARD and set error bit1.
  - Write mode: latch the channel and go to RECEIVE.
  - Flush mode: pulse fifo_flush[ch] on the following cycle, then go to DISCARD.
- RECEIVE:
  - Bytes are packed MSB-first: byte i lands at bits [(RecordBytes-1-i)*8 +: 8].
  - When the last byte of a record arrives and free_slots[ch] is nonzero, fifo_write_en[ch] is high for exactly one cycle on the next cycle, with fifo_record stable.
  - If free_slots[ch] is 0 at that byte, the record is dropped and error bit2 (overflow) is set.
  - The counter returns to 0 and the state stays RECEIVE, so back-to-back records in one transaction are accepted.
  - Latency: one clock from the final word_ready to the write pulse.
  - If spi_cs rises in the same cycle the write pulse is issued, the write still completes.
- STATUS (k counts bytes sent after the command):
  - tx_byte = free_slots[k] for k < NumChannels.
  - k = NumChannels returns {4'b0, error_flags}; the word_ready that completes this byte clears error_flags.
  - After that, tx_byte returns 0; k saturates.
- DISCARD: all bytes are ignored until spi_cs goes high.
- tx_byte is combinational from state and k.
  - In IDLE it is the minimum free_slots over all channels, so one byte suffices for flow control.
  - In SELECT, RECEIVE and DISCARD it is 0.
- Error bits are sticky and OR-accumulate. They are cleared only by rst or by a status read; a set event in the same cycle as a clear wins.
- Write and flush pulses are never asserted for more than one channel at once.

Decomposition:
- Package beagleg:
  - Add CMD_FLUSH_FIFO next to CMD_STATUS and CMD_WRITE_FIFO.
  - Add error bit index constants ERR_UNKNOWN_CMD=0, ERR_BAD_CHANNEL=1, ERR_OVERFLOW=2, ERR_TRUNCATED=3.
- The state enum stays local to the module.
- One sub-module, record_assembler: byte counter plus staging shift register.
  - Inputs: clear, byte strobe, byte.
  - Outputs: record, record_done.

Test Plan:
- Reset; then CMD_STATUS plus 5 bytes with free_slots={16,3,0,9} -> tx_byte sequence 16,3,0,9,0x00; IDLE tx_byte = 0.
- CMD_WRITE_FIFO, channel 2, two full records with free_slots[2]=5 -> exactly two fifo_write_en=4'b0100 pulses, each one cycle after its last byte, fifo_record equal to the sent bytes MSB-first.
- Write to a channel whose free_slots=0 -> no write pulse, error_flags=4'b0100; a following status read returns 0x04 at byte NumChannels, then error_flags=0.
- spi_cs rises after 3 of RecordBytes bytes -> no write pulse, error bit3 set; next transaction decodes a fresh command byte.
- Channel byte 7 with NumChannels=4 -> error bit1 set, no pulses; unknown command 0xEE -> bit0 set, later bytes ignored until spi_cs is high.
- CMD_FLUSH_FIFO, channel 1 -> fifo_flush=4'b0010 for exactly one cycle; rst asserted mid-record -> all outputs 0 on the next cycle and no write.
